regfile_sb: RTL

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 73 +++++++
 rtl/regfile_sb.sv | 93 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and the address-width helper for the register file slice.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned NRD_DEF   = 2;
  localparam int unsigned NWR_DEF   = 2;

  // Address width for a register count; never below one bit.
  function automatic int unsigned aw_of(input int unsigned nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a registered population count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned NREGS = NREGS_DEF,
  parameter  int unsigned NWR   = NWR_DEF,
  localparam int unsigned AW    = aw_of(NREGS),
  localparam int unsigned CW    = AW + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NWR-1:0]          wcommit_i,
  input  logic [NWR-1:0][AW-1:0]  waddr_i,
  input  logic                    iss_valid_i,
  input  logic [AW-1:0]           iss_rd_i,
  input  logic                    flush_i,
  output logic [NREGS-1:0]        busy_o,
  output logic                    iss_ready_c,
  output logic [CW-1:0]           busy_cnt_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             issue_acc_c;

  // Issue handshake; only stored state is consulted, a same-cycle write is not forwarded.
  always_comb begin
    iss_ready_c = (iss_rd_i == '0) || !busy_q[iss_rd_i];
    issue_acc_c = iss_valid_i && iss_ready_c && (iss_rd_i != '0);
  end

  // Next busy vector: write clears, then issue set (set wins), then flush clears everything.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < int'(NWR); i++) begin
      if (wcommit_i[i]) begin
        busy_d[waddr_i[i]] = 1'b0;
      end
    end
    if (issue_acc_c) begin
      busy_d[iss_rd_i] = 1'b1;
    end
    if (flush_i) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  // Population count of the next busy vector so the count lands on the same edge.
  always_comb begin
    cnt_d = '0;
    for (int k = 0; k < int'(NREGS); k++) begin
      cnt_d = cnt_d + CW'(busy_d[k]);
    end
  end

  // Scoreboard state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-ported register file with write forwarding and a pending-write scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN   = XLEN_DEF,
  parameter  int unsigned NREGS  = NREGS_DEF,
  parameter  int unsigned NRD    = NRD_DEF,
  parameter  int unsigned NWR    = NWR_DEF,
  parameter  bit          BYPASS = 1'b1,
  localparam int unsigned AW     = aw_of(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NWR-1:0]           we,
  input  logic [NWR-1:0][AW-1:0]   waddr,
  input  logic [NWR-1:0][XLEN-1:0] wdata,
  input  logic [NRD-1:0][AW-1:0]   raddr,
  output logic [NRD-1:0][XLEN-1:0] rdata,
  output logic [NRD-1:0]           rbusy,
  input  logic                     iss_valid,
  input  logic [AW-1:0]            iss_rd,
  output logic                     iss_ready,
  input  logic                     flush,
  output logic [AW:0]              busy_cnt
);

  logic [NREGS-1:0][XLEN-1:0] regs_q;
  logic [NREGS-1:0][XLEN-1:0] regs_d;
  logic [NWR-1:0]             wcommit_c;
  logic [NREGS-1:0]           busy_vec;

  // A write commits only when enabled and not aimed at the hardwired-zero register.
  always_comb begin
    wcommit_c = '0;
    for (int i = 0; i < int'(NWR); i++) begin
      wcommit_c[i] = we[i] && (waddr[i] != '0);
    end
  end

  // Next storage state; later ports overwrite earlier ones so the highest index wins.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < int'(NWR); i++) begin
      if (wcommit_c[i]) begin
        regs_d[waddr[i]] = wdata[i];
      end
    end
  end

  // Storage array; entry 0 is never written so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Combinational read ports with optional same-cycle forwarding (highest write port wins).
  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int j = 0; j < int'(NRD); j++) begin
      rdata[j] = regs_q[raddr[j]];
      rbusy[j] = busy_vec[raddr[j]];
      if (BYPASS) begin
        for (int i = 0; i < int'(NWR); i++) begin
          if (wcommit_c[i] && (waddr[i] == raddr[j])) begin
            rdata[j] = wdata[i];
            rbusy[j] = 1'b0;
          end
        end
      end
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .wcommit_i   (wcommit_c),
    .waddr_i     (waddr),
    .iss_valid_i (iss_valid),
    .iss_rd_i    (iss_rd),
    .flush_i     (flush),
    .busy_o      (busy_vec),
    .iss_ready_c (iss_ready),
    .busy_cnt_o  (busy_cnt)
  );

endmodule
